intersection_coordinator: RTL and testbench
===========================================

Name: intersection_coordinator

Overview:
- Right-of-way sequencer driving two single-approach light units: approach A (main road) and approach B (cross road).
- It is the counterpart of the units' feedback/currentState reporting. It consumes each unit's phase-done pulse and state code, and drives each unit's enb/set/lastState inputs.
- Only one approach is ever released; the other is frozen in RED.
- Sits between the top-level mode select and the two light units. It is clocked by the system clock and advances only on the shared 1 s tick.

Parameters:
- MAX_PHASE, 40: watchdog limit, in ticks, for one approach's RUN phase (GREEN+YELLOW is nominally 21).
- CNT_W, 6: width of the watchdog counter; must hold MAX_PHASE.

Ports:
- clk  in  1  system clock; all logic is rising-edge.
- rst_n  in  1  asynchronous active-low reset.
- tick  in  1  one-clk-wide enable at 1 Hz; the light units step on the same tick.
- start  in  1  level request to run or re-run the sequence.
- peak_in  in  1  peak-hour flag.
- fb_a, fb_b  in  1  unit phase-done pulses, valid on tick.
- state_a, state_b  in  2  unit currentState codes: RED=00, YELLOW=01, GREEN=10, 11 undefined.
- enb_a, enb_b  out  1  unit enable; 0 means the unit loads the light following last_x.
- set_a, set_b  out  1  unit run; 0 with enb=1 means the unit is frozen.
- last_a, last_b  out  2  lastState code presented to each unit.
- peak_out  out  1  registered peak flag to the units.
- owner  out  1  0 = A holds right-of-way, 1 = B holds it.
- fault  out  1  sticky fault flag.
- handoffs  out  8  wrapping count of completed handoffs.

Behaviour:
- All state, counter and output updates occur only on clk edges with tick=1. Between ticks, outputs are stable.
- Reset (rst_n=0, asynchronous):
  - state=IDLE, enb_a=enb_b=1, set_a=set_b=0, last_a=last_b=RED.
  - peak_out=0, owner=0, fault=0, handoffs=0, watchdog=0.
  - Reset takes effect mid-phase or mid-handoff with no completion.
- peak_out <= peak_in on every tick, in every state.
- IDLE: both units frozen. If start=1, go to LOAD.
- LOAD (exactly one tick):
  - enb_a=0, last_a=RED, so A loads GREEN.
  - enb_b=0, last_b=YELLOW, so B loads RED.
  - set_a=set_b=0.
  - Next tick: RUN_A, owner=0, watchdog=0.
- RUN_A:
  - enb_a=1, set_a=1, enb_b=1, set_b=0.
  - watchdog increments each tick.
  - fb_a=1 with state_a=YELLOW: A has just entered RED; go to HANDOFF_AB.
  - fb_a=1 with state_a=GREEN: normal GREEN to YELLOW transition; no action.
- HANDOFF_AB (one tick):
  - set_a=0 (A frozen in RED); enb_b=0, last_b=RED, so B loads GREEN.
  - Next: RUN_B, owner=1, watchdog=0, handoffs+1 (wraps 255 to 0).
- RUN_B and HANDOFF_BA: mirror of RUN_A and HANDOFF_AB with A and B swapped; HANDOFF_BA leads to RUN_A.
- Fault conditions, checked on a tick in RUN_x. Any one sends the block to FAULT on that tick:
  - fb of the frozen unit is 1.
  - fb of the running unit is 1 with its state equal to RED or 11.
  - watchdog reaches MAX_PHASE.
  - If a fault and a valid handoff coincide, the fault wins.
- FAULT:
  - fault=1.
  - enb_a=enb_b=0, last_a=last_b=YELLOW held continuously, so both units reload RED every tick.
  - set_a=set_b=0.
  - Exit only via start=1 on a tick: fault cleared, go to LOAD. start=0 holds FAULT indefinitely.
- start=0 during RUN or HANDOFF has no effect; the sequence continues.
- Handoff detection is evaluated only in RUN_x; fb inputs are ignored in IDLE and LOAD.

Test Plan:
- Reset state: reset asserted with no ticks -> enb=1, set=0, last=00, fault=0, handoffs=0; 50 ticks with start=0 -> still IDLE.
- Startup: start=1 on a tick -> next tick enb_a=0, last_a=00, enb_b=0, last_b=01; following tick set_a=1, set_b=0, owner=0.
- Handoff: in RUN_A, fb_a=1/state_a=10 at tick 16 -> no change; fb_a=1/state_a=01 at tick 21 -> one tick with enb_b=0, last_b=00, set_a=0; then owner=1, handoffs=1.
- Watchdog: RUN_B with no fb for 40 ticks -> fault=1, both enb=0 with last=01. start=1 -> LOAD; fault=0 on the next tick.
- Frozen-unit fault: in RUN_A, fb_b=1 -> FAULT on that tick; also fb_a=1 with state_a=00 -> FAULT.
- Wrap and reset: 256 handoffs -> handoffs=0. rst_n low during HANDOFF_AB -> immediate IDLE values, with no tick required.

Source files
------------

// File: rtl/intersection_coordinator.sv
// Right-of-way sequencer for two single-approach light units (A = main, B = cross).
// Advances only on the shared 1 Hz tick; exactly one approach runs while the other is frozen in RED.
module intersection_coordinator #(
  parameter int unsigned MAX_PHASE = 40,
  parameter int unsigned CNT_W     = 6
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick,
  input  logic       start,
  input  logic       peak_in,
  input  logic       fb_a,
  input  logic       fb_b,
  input  logic [1:0] state_a,
  input  logic [1:0] state_b,
  output logic       enb_a,
  output logic       enb_b,
  output logic       set_a,
  output logic       set_b,
  output logic [1:0] last_a,
  output logic [1:0] last_b,
  output logic       peak_out,
  output logic       owner,
  output logic       fault,
  output logic [7:0] handoffs
);

  localparam logic [1:0] RED = 2'b00;
  localparam logic [1:0] YEL = 2'b01;
  localparam logic [1:0] UND = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_RUN_A, S_HAND_AB, S_RUN_B, S_HAND_BA, S_FAULT
  } state_e;

  state_e           state_q, state_d;
  logic             owner_q, owner_d;
  logic [CNT_W-1:0] wd_q, wd_d;
  logic [7:0]       hand_q, hand_d;
  logic             peak_q;

  logic             run_b;
  logic             fb_run, fb_frz;
  logic [1:0]       st_run;
  logic [CNT_W-1:0] wd_inc;
  logic             bad, done;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      owner_q <= 1'b0;
      wd_q    <= '0;
      hand_q  <= '0;
      peak_q  <= 1'b0;
    end else if (tick) begin
      state_q <= state_d;
      owner_q <= owner_d;
      wd_q    <= wd_d;
      hand_q  <= hand_d;
      peak_q  <= peak_in;
    end
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    wd_d    = wd_q;
    hand_d  = hand_q;

    // Fold RUN_A/RUN_B onto one running/frozen view so the checks are written once.
    run_b  = (state_q == S_RUN_B);
    fb_run = run_b ? fb_b : fb_a;
    st_run = run_b ? state_b : state_a;
    fb_frz = run_b ? fb_a : fb_b;
    wd_inc = wd_q + CNT_W'(1);
    bad    = fb_frz | (fb_run & ((st_run == RED) | (st_run == UND)))
           | (wd_inc == CNT_W'(MAX_PHASE));
    done   = fb_run & (st_run == YEL);

    case (state_q)
      S_IDLE:  if (start) state_d = S_LOAD;
      S_FAULT: if (start) state_d = S_LOAD;
      S_LOAD: begin
        state_d = S_RUN_A;
        owner_d = 1'b0;
        wd_d    = '0;
      end
      S_RUN_A, S_RUN_B: begin
        wd_d = wd_inc;
        if (bad)       state_d = S_FAULT;
        else if (done) state_d = run_b ? S_HAND_BA : S_HAND_AB;
      end
      S_HAND_AB: begin
        state_d = S_RUN_B;
        owner_d = 1'b1;
        wd_d    = '0;
        hand_d  = hand_q + 8'd1;
      end
      S_HAND_BA: begin
        state_d = S_RUN_A;
        owner_d = 1'b0;
        wd_d    = '0;
        hand_d  = hand_q + 8'd1;
      end
      default: state_d = S_IDLE;
    endcase

    enb_a  = 1'b1;
    enb_b  = 1'b1;
    set_a  = 1'b0;
    set_b  = 1'b0;
    last_a = RED;
    last_b = RED;
    case (state_q)
      S_LOAD: begin
        enb_a  = 1'b0;
        enb_b  = 1'b0;
        last_b = YEL;
      end
      S_RUN_A:   set_a = 1'b1;
      S_RUN_B:   set_b = 1'b1;
      S_HAND_AB: enb_b = 1'b0;
      S_HAND_BA: enb_a = 1'b0;
      S_FAULT: begin
        enb_a  = 1'b0;
        enb_b  = 1'b0;
        last_a = YEL;
        last_b = YEL;
      end
      default: ;
    endcase
  end

  assign peak_out = peak_q;
  assign owner    = owner_q;
  assign fault    = (state_q == S_FAULT);
  assign handoffs = hand_q;

endmodule

// File: tb/tb_intersection_coordinator.sv
// Randomized bench for intersection_coordinator against a phase-level reference model.
module tb_intersection_coordinator;

  localparam int MAX = 40;
  localparam int P_IDLE = 0, P_LOAD = 1, P_RUN = 2, P_HAND = 3, P_FAULT = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0, tick = 1'b0, start = 1'b0, peak_in = 1'b0, fb_a = 1'b0, fb_b = 1'b0;
  logic [1:0] state_a = 2'b00, state_b = 2'b00;
  logic enb_a, enb_b, set_a, set_b, peak_out, owner, fault;
  logic [1:0] last_a, last_b;
  logic [7:0] handoffs;

  intersection_coordinator #(.MAX_PHASE(40), .CNT_W(6)) dut (
    .clk(clk), .rst_n(rst_n), .tick(tick), .start(start), .peak_in(peak_in),
    .fb_a(fb_a), .fb_b(fb_b), .state_a(state_a), .state_b(state_b),
    .enb_a(enb_a), .enb_b(enb_b), .set_a(set_a), .set_b(set_b),
    .last_a(last_a), .last_b(last_b), .peak_out(peak_out), .owner(owner),
    .fault(fault), .handoffs(handoffs)
  );

  always #5 clk = ~clk;

  int nvec = 0, nerr = 0;

  // Model: phase, which approach is running (0=A,1=B), ticks spent in RUN, counters.
  int m_phase, m_run, m_owner, m_wd, m_hand, m_peak;

  task automatic model_reset();
    m_phase = P_IDLE; m_run = 0; m_owner = 0; m_wd = 0; m_hand = 0; m_peak = 0;
  endtask

  task automatic model_tick(input logic s, input logic pk, input logic fa, input logic fbb,
                            input logic [1:0] sa, input logic [1:0] sb);
    logic fr, ff;
    logic [1:0] sr;
    m_peak = pk;
    case (m_phase)
      P_IDLE, P_FAULT: if (s) m_phase = P_LOAD;
      P_LOAD: begin m_phase = P_RUN; m_run = 0; m_owner = 0; m_wd = 0; end
      P_RUN: begin
        fr = m_run ? fbb : fa;
        sr = m_run ? sb : sa;
        ff = m_run ? fa : fbb;
        m_wd = m_wd + 1;
        if (ff || (fr && (sr == 2'd0 || sr == 2'd3)) || m_wd >= MAX) m_phase = P_FAULT;
        else if (fr && sr == 2'd1) m_phase = P_HAND;
      end
      P_HAND: begin
        m_run = 1 - m_run; m_owner = m_run; m_wd = 0;
        m_hand = (m_hand + 1) % 256; m_phase = P_RUN;
      end
      default: ;
    endcase
  endtask

  function automatic logic [18:0] model_out();
    logic ea, sa, eb, sb;
    logic [1:0] la, lb;
    ea = 1; sa = 0; eb = 1; sb = 0; la = 2'b00; lb = 2'b00;
    case (m_phase)
      P_LOAD:  begin ea = 0; eb = 0; lb = 2'b01; end
      P_RUN:   if (m_run == 0) sa = 1; else sb = 1;
      P_HAND:  if (m_run == 0) eb = 0; else ea = 0;
      P_FAULT: begin ea = 0; eb = 0; la = 2'b01; lb = 2'b01; end
      default: ;
    endcase
    return {ea, sa, la, eb, sb, lb, 1'(m_peak), 1'(m_owner), m_phase == P_FAULT, 8'(m_hand)};
  endfunction

  function automatic logic [18:0] dut_out();
    return {enb_a, set_a, last_a, enb_b, set_b, last_b, peak_out, owner, fault, handoffs};
  endfunction

  task automatic apply_tick(input logic s, input logic fa, input logic fbb,
                            input logic [1:0] sa, input logic [1:0] sb);
    logic pk;
    pk = 1'($urandom_range(0, 1));
    @(negedge clk);
    start = s; peak_in = pk; fb_a = fa; fb_b = fbb; state_a = sa; state_b = sb; tick = 1'b1;
    @(posedge clk);
    #1 tick = 1'b0;
    model_tick(s, pk, fa, fbb, sa, sb);
  endtask

  task automatic plain_tick(input logic s);
    apply_tick(s, 1'b0, 1'b0, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)));
  endtask

  task automatic test_reset();
    logic [18:0] got, exp;
    rst_n = 1'b0; tick = 1'b0;
    repeat (3) @(negedge clk);
    model_reset();
    got = dut_out(); exp = model_out(); nvec++;
    if (got !== exp) begin nerr++; $display("FAIL reset got=%h exp=%h", got, exp); end
    @(negedge clk) rst_n = 1'b1;
    for (int i = 0; i < 50; i++) begin
      apply_tick(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)));
      got = dut_out(); exp = model_out(); nvec++;
      if (got !== exp) begin nerr++; $display("FAIL idle_hold i=%0d got=%h exp=%h", i, got, exp); end
    end
  endtask

  task automatic test_startup();
    logic [18:0] got, exp;
    plain_tick(1'b1);
    got = dut_out(); exp = model_out(); nvec++;
    if (got !== exp) begin nerr++; $display("FAIL load got=%h exp=%h", got, exp); end
    nvec++;
    if ({enb_a, last_a, enb_b, last_b} !== 6'b0_00_0_01) begin
      nerr++; $display("FAIL load_fields got=%b exp=000001", {enb_a, last_a, enb_b, last_b});
    end
    plain_tick(1'b0);
    got = dut_out(); exp = model_out(); nvec++;
    if (got !== exp) begin nerr++; $display("FAIL run_a_entry got=%h exp=%h", got, exp); end
  endtask

  task automatic test_handoff();
    logic [18:0] got, exp;
    for (int k = 1; k <= 21; k++) begin
      apply_tick(1'b0, (k == 16 || k == 21), 1'b0, (k == 21) ? 2'b01 : 2'b10, 2'b00);
      got = dut_out(); exp = model_out(); nvec++;
      if (got !== exp) begin nerr++; $display("FAIL handoff_ab k=%0d got=%h exp=%h", k, got, exp); end
    end
    plain_tick(1'b0);
    got = dut_out(); exp = model_out(); nvec++;
    if (got !== exp) begin nerr++; $display("FAIL run_b_entry got=%h exp=%h", got, exp); end
    nvec++;
    if ({owner, handoffs} !== 9'h101) begin
      nerr++; $display("FAIL owner_count got=%h exp=101", {owner, handoffs});
    end
  endtask

  task automatic test_watchdog();
    logic [18:0] got, exp;
    for (int k = 1; k <= 40; k++) begin
      plain_tick(1'b0);
      got = dut_out(); exp = model_out(); nvec++;
      if (got !== exp) begin nerr++; $display("FAIL watchdog k=%0d got=%h exp=%h", k, got, exp); end
    end
    nvec++;
    if (fault !== 1'b1) begin nerr++; $display("FAIL watchdog_fault got=%b exp=1", fault); end
    for (int k = 0; k < 5; k++) begin
      apply_tick(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 2'b01, 2'b01);
      got = dut_out(); exp = model_out(); nvec++;
      if (got !== exp) begin nerr++; $display("FAIL fault_hold k=%0d got=%h exp=%h", k, got, exp); end
    end
    plain_tick(1'b1);
    got = dut_out(); exp = model_out(); nvec++;
    if (got !== exp) begin nerr++; $display("FAIL fault_exit got=%h exp=%h", got, exp); end
  endtask

  task automatic test_frozen_fault();
    // {start, fb_a, fb_b, state_a, state_b}; begins in LOAD
    logic [6:0] tbl [19] = '{
      7'b0_0_0_10_00, 7'b0_0_0_10_00, 7'b0_0_0_10_00, 7'b0_0_1_10_00,
      7'b1_0_0_00_00, 7'b0_0_0_00_00, 7'b0_1_0_00_00,
      7'b1_0_0_00_00, 7'b0_0_0_00_00, 7'b0_1_0_01_00, 7'b0_0_0_00_00, 7'b0_0_1_00_11,
      7'b1_0_0_00_00, 7'b0_0_0_00_00, 7'b0_1_1_01_10,
      7'b1_0_0_00_00, 7'b0_0_0_00_00, 7'b0_1_0_01_00, 7'b0_0_0_00_00
    };
    logic [18:0] got, exp;
    logic [6:0] e;
    for (int i = 0; i < 19; i++) begin
      e = tbl[i];
      apply_tick(e[6], e[5], e[4], e[3:2], e[1:0]);
      got = dut_out(); exp = model_out(); nvec++;
      if (got !== exp) begin nerr++; $display("FAIL frozen_fault i=%0d got=%h exp=%h", i, got, exp); end
    end
  endtask

  function automatic logic [1:0] rand_state();
    int r;
    r = $urandom_range(0, 9);
    return (r < 4) ? 2'b01 : (r < 8) ? 2'b10 : (r == 8) ? 2'b00 : 2'b11;
  endfunction

  task automatic test_random();
    logic [18:0] got, exp;
    for (int i = 0; i < 800; i++) begin
      apply_tick($urandom_range(0, 7) == 0, $urandom_range(0, 11) == 0,
                 $urandom_range(0, 11) == 0, rand_state(), rand_state());
      got = dut_out(); exp = model_out(); nvec++;
      if (got !== exp) begin nerr++; $display("FAIL random i=%0d got=%h exp=%h", i, got, exp); end
      repeat ($urandom_range(0, 2)) begin
        @(negedge clk);
        start = 1'($urandom_range(0, 1)); fb_a = 1'($urandom_range(0, 1));
        fb_b = 1'($urandom_range(0, 1)); peak_in = 1'($urandom_range(0, 1));
        @(posedge clk); #1;
        got = dut_out(); nvec++;
        if (got !== exp) begin nerr++; $display("FAIL no_tick_stable i=%0d got=%h exp=%h", i, got, exp); end
      end
    end
  endtask

  task automatic test_wrap();
    logic [18:0] got, exp;
    @(negedge clk) rst_n = 1'b0;
    #1 model_reset();
    @(negedge clk) rst_n = 1'b1;
    plain_tick(1'b1);
    plain_tick(1'b0);
    for (int i = 0; i < 256; i++) begin
      if (m_run == 0) apply_tick(1'b0, 1'b1, 1'b0, 2'b01, 2'b00);
      else            apply_tick(1'b0, 1'b0, 1'b1, 2'b00, 2'b01);
      plain_tick(1'b0);
      got = dut_out(); exp = model_out(); nvec++;
      if (got !== exp) begin nerr++; $display("FAIL wrap i=%0d got=%h exp=%h", i, got, exp); end
    end
    nvec++;
    if (handoffs !== 8'd0) begin nerr++; $display("FAIL wrap_zero got=%0d exp=0", handoffs); end
  endtask

  task automatic test_reset_midhandoff();
    logic [18:0] got, exp;
    if (m_run == 0) apply_tick(1'b0, 1'b1, 1'b0, 2'b01, 2'b00);
    else            apply_tick(1'b0, 1'b0, 1'b1, 2'b00, 2'b01);
    got = dut_out(); exp = model_out(); nvec++;
    if (got !== exp) begin nerr++; $display("FAIL in_handoff got=%h exp=%h", got, exp); end
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 model_reset();
    got = dut_out(); exp = model_out(); nvec++;
    if (got !== exp) begin nerr++; $display("FAIL async_reset got=%h exp=%h", got, exp); end
    @(negedge clk) rst_n = 1'b1;
    plain_tick(1'b0);
    got = dut_out(); exp = model_out(); nvec++;
    if (got !== exp) begin nerr++; $display("FAIL post_reset_idle got=%h exp=%h", got, exp); end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_startup();
    test_handoff();
    test_watchdog();
    test_frozen_fault();
    test_random();
    test_wrap();
    test_reset_midhandoff();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
